// File: rtl/capture_pkg.sv
// Shared types and default sizes for the scope sample capture buffer.
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT,
        ST_POST,
        ST_DONE
    } cap_state_t;

    localparam int CAP_DEPTH = 256;
    localparam int CAP_SW    = 8;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read.
module capture_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int SW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [SW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [SW-1:0] rdata
);

    logic [SW-1:0] mem [DEPTH];

    // Array is deliberately not reset so a captured frame survives rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/capture_buffer.sv
// Circular sample capture with programmable pre-trigger; frame frozen in DONE.
// Optional build macro CAP_AUTO_REARM_EN adds HOLD-cycle auto re-arm and the freeze input.
//
//   state | meaning
//   IDLE  | not armed, no writes
//   FILL  | writing the pre-trigger portion, triggers ignored
//   WAIT  | writing, waiting for trig_en
//   POST  | writing the post-trigger portion, triggers ignored
//   DONE  | frame frozen, readable
module capture_buffer
    import capture_pkg::*;
#(
    parameter int DEPTH    = CAP_DEPTH,
    parameter int AW       = $clog2(DEPTH),
    parameter int SW       = CAP_SW,
    parameter int TRIG_LAG = 1
`ifdef CAP_AUTO_REARM_EN
    ,
    parameter int HOLD     = 1024
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [SW-1:0] sample,
    input  logic          trig_en,
    input  logic          arm,
    input  logic [AW-1:0] pretrig,
    input  logic [AW-1:0] rd_addr,
    output logic [SW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] trig_addr
`ifdef CAP_AUTO_REARM_EN
    ,
    input  logic          freeze
`endif
);

    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] LAG    = AW'(TRIG_LAG);
    localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PT_MAX = AW'(DEPTH - 1 - TRIG_LAG);

`ifdef CAP_AUTO_REARM_EN
    localparam int              HOLD_W    = $clog2(HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD);
    logic [HOLD_W-1:0] hold_cnt;
    logic [AW-1:0]     fill_cur;
`endif

    cap_state_t    state;
    logic [AW-1:0] wp;
    logic [AW-1:0] pt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] pt_arm;
    logic [AW-1:0] fill_arm;
    logic [AW-1:0] rem;
    logic [AW-1:0] start;
    logic [AW-1:0] rd_ram;

    assign pt_arm   = (pretrig > PT_MAX) ? PT_MAX : pretrig;
    assign fill_arm = pt_arm + LAG;
    assign rem      = LAST - pt - LAG;
    assign start    = trig_addr - pt;
    assign rd_ram   = start + rd_addr;
`ifdef CAP_AUTO_REARM_EN
    assign fill_cur = pt + LAG;
`endif

    // busy doubles as the RAM write enable: it is high exactly in FILL/WAIT/POST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wp        <= '0;
            pt        <= '0;
            cnt       <= '0;
            trig_addr <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CAP_AUTO_REARM_EN
            hold_cnt  <= '0;
`endif
        end else begin
            if (busy) begin
                wp <= wp + ONE;
            end
`ifdef CAP_AUTO_REARM_EN
            if (state != ST_DONE) begin
                hold_cnt <= HOLD_LOAD;
            end
`endif
            if (arm) begin
                pt    <= pt_arm;
                wp    <= '0;
                cnt   <= fill_arm;
                busy  <= 1'b1;
                done  <= 1'b0;
                state <= (fill_arm == '0) ? ST_WAIT : ST_FILL;
            end else begin
                case (state)
                    ST_FILL: begin
                        if (cnt == ONE) begin
                            state <= ST_WAIT;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
                    ST_WAIT: begin
                        if (trig_en) begin
                            trig_addr <= wp - LAG;
                            if (rem != '0) begin
                                cnt   <= rem;
                                state <= ST_POST;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                    ST_POST: begin
                        if (cnt == ONE) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt - ONE;
                        end
                    end
`ifdef CAP_AUTO_REARM_EN
                    ST_DONE: begin
                        if (hold_cnt == HOLD_ONE) begin
                            hold_cnt <= '0;
                            if (!freeze) begin
                                wp    <= '0;
                                cnt   <= fill_cur;
                                busy  <= 1'b1;
                                done  <= 1'b0;
                                state <= (fill_cur == '0) ? ST_WAIT : ST_FILL;
                            end
                        end else if (hold_cnt != '0) begin
                            hold_cnt <= hold_cnt - HOLD_ONE;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .SW    (SW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (busy),
        .waddr (wp),
        .wdata (sample),
        .raddr (rd_ram),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_capture_buffer.sv
// Scoreboard bench for capture_buffer: logs every driven sample and predicts each frame readback.
module tb_capture_buffer;

   localparam int DEPTH = 256;
   localparam int LAG   = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sample;
   logic       trig_en;
   logic       arm;
   logic [7:0] pretrig;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;
   logic       done;
   logic [7:0] trig_addr;
`ifdef CAP_AUTO_REARM_EN
   logic       freeze;
`endif

   int         n_chk = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         pat = 0;
   int         overlap = 0;
   logic [7:0] slog [0:16383];
   int         exp_q [$];

   always #5 clk = ~clk;

`ifdef CAP_AUTO_REARM_EN
   capture_buffer #(.HOLD(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .sample    (sample),
      .trig_en   (trig_en),
      .arm       (arm),
      .pretrig   (pretrig),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .trig_addr (trig_addr),
      .freeze    (freeze)
   );
`else
   capture_buffer dut (
      .clk       (clk),
      .rst       (rst),
      .sample    (sample),
      .trig_en   (trig_en),
      .arm       (arm),
      .pretrig   (pretrig),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .trig_addr (trig_addr)
   );
`endif

   always @(negedge clk) begin
      if (busy && done) overlap++;
   end

   task automatic check_val(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Advance to the next negedge and drive that cycle's sample.
   task automatic tick();
      @(negedge clk);
      cyc++;
      sample = (pat == 0) ? 8'(cyc % 256) : 8'((cyc * 37 + 11) % 256);
      slog[cyc] = sample;
   endtask

   task automatic read_frame(input int ptc, input int t_cyc);
      for (int i = 0; i < DEPTH; i++) begin
         rd_addr = 8'(i);
         exp_q.push_back(int'(slog[t_cyc - LAG - ptc + i]));
         tick();
         check_val($sformatf("rd[%0d]", i), int'(rd_data), exp_q.pop_front());
      end
   endtask

   task automatic capture(input int ptv, input bit fill_glitch, input bit post_glitch);
      int ptc;
      int a_cyc;
      int t_cyc;
      ptc = (ptv > DEPTH - 1 - LAG) ? DEPTH - 1 - LAG : ptv;
      tick();
      arm = 1'b1;
      pretrig = 8'(ptv);
      a_cyc = cyc;
      tick();
      arm = 1'b0;
      check_val("busy_after_arm", int'(busy), 1);
      for (int j = 0; j < ptc + 5; j++) begin
         tick();
         trig_en = fill_glitch && (j == 1);
      end
      trig_en = 1'b1;
      t_cyc = cyc;
      do begin
         tick();
         trig_en = post_glitch && (cyc == t_cyc + 3);
      end while (!done && (cyc - t_cyc) < 600);
      trig_en = 1'b0;
      check_val("done_lat", cyc - t_cyc, DEPTH - LAG - ptc);
      check_val("busy_in_done", int'(busy), 0);
      check_val("trig_addr", int'(trig_addr), (t_cyc - a_cyc - 1 - LAG) & (DEPTH - 1));
      read_frame(ptc, t_cyc);
   endtask

   initial begin
      rst = 1'b1;
      sample = '0;
      trig_en = 1'b0;
      arm = 1'b0;
      pretrig = '0;
      rd_addr = '0;
`ifdef CAP_AUTO_REARM_EN
      freeze = 1'b1;
`endif
      tick();
      tick();
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_trig_addr", int'(trig_addr), 0);
      check_val("rst_rd_data", int'(rd_data), 0);
      tick();
      rst = 1'b0;
      repeat (3) tick();
      check_val("idle_busy", int'(busy), 0);

      // Ramp, pretrig 10
      pat = 0;
      capture(10, 1'b0, 1'b0);
      // Scrambled pattern, boundary pre-trigger values
      pat = 1;
      capture(0, 1'b0, 1'b0);
      capture(255, 1'b0, 1'b0);
      // Stray pulses in FILL and POST
      capture(20, 1'b1, 1'b1);

      // Re-arm in the middle of POST
      tick();
      arm = 1'b1;
      pretrig = 8'd100;
      tick();
      arm = 1'b0;
      repeat (110) tick();
      trig_en = 1'b1;
      tick();
      trig_en = 1'b0;
      repeat (5) tick();
      check_val("busy_mid_post", int'(busy), 1);
      capture(50, 1'b0, 1'b0);

      // Reset while waiting for a trigger
      tick();
      arm = 1'b1;
      pretrig = 8'd30;
      tick();
      arm = 1'b0;
      repeat (40) tick();
      rst = 1'b1;
      #1;
      check_val("wrst_busy", int'(busy), 0);
      check_val("wrst_done", int'(done), 0);
      check_val("wrst_trig_addr", int'(trig_addr), 0);
      check_val("wrst_rd_data", int'(rd_data), 0);
      tick();
      rst = 1'b0;
      tick();
      check_val("wrst_idle", int'(busy), 0);
      pat = 0;
      capture(77, 1'b0, 1'b0);

`ifdef CAP_AUTO_REARM_EN
      begin
         int d_cyc;
         tick();
         arm = 1'b1;
         pretrig = 8'd40;
         tick();
         arm = 1'b0;
         freeze = 1'b0;
         repeat (45) tick();
         trig_en = 1'b1;
         tick();
         trig_en = 1'b0;
         while (!done && cyc < 20000) tick();
         d_cyc = cyc;
         while (!busy && (cyc - d_cyc) < 100) tick();
         check_val("rearm_lat", cyc - d_cyc, 16);
         repeat (45) tick();
         trig_en = 1'b1;
         tick();
         trig_en = 1'b0;
         freeze = 1'b1;
         d_cyc = cyc;
         while (!done && (cyc - d_cyc) < 600) tick();
         check_val("rearm_done", int'(done), 1);
         repeat (40) tick();
         check_val("freeze_done", int'(done), 1);
         check_val("freeze_busy", int'(busy), 0);
      end
`endif

      check_val("busy_done_overlap", overlap, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
